alu_operand_issue: RTL

- Producer side of the execute-stage ALU interface. Decodes one RV32I instruction per handshake into the ALU operands A and B and the 3-bit ALU_CONTROL, plus writeback metadata.
- Registers the result in a single-entry pipeline register (ID/EX boundary) with a valid/ready handshake on both sides and a synchronous flush.
- Sits between the register-file read and the ALU.

---
 rtl/alu_operand_issue.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/alu_operand_issue.sv
// RV32I decode into ALU operands A/B, ALU_CONTROL and writeback metadata, held in a
// single-entry ID/EX register with valid/ready on both sides and a synchronous flush.
`ifndef ALU_ADD
`define ALU_ADD 3'd0
`define ALU_SUB 3'd1
`define ALU_AND 3'd2
`define ALU_OR  3'd3
`define ALU_XOR 3'd4
`endif

module alu_operand_issue #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [XLEN-1:0] INSTR,
  input  logic [XLEN-1:0] PC,
  output logic [4:0]      RS1_IDX,
  output logic [4:0]      RS2_IDX,
  input  logic [XLEN-1:0] RS1_DATA,
  input  logic [XLEN-1:0] RS2_DATA,
  input  logic            FLUSH,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [2:0]      ALU_CONTROL,
  output logic [4:0]      RD,
  output logic            RD_WE,
  output logic [XLEN-1:0] PC_OUT,
  output logic            ILLEGAL
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd_idx;
  logic [XLEN-1:0] imm_i, imm_s, imm_u;

  assign opcode  = INSTR[6:0];
  assign funct3  = INSTR[14:12];
  assign funct7  = INSTR[31:25];
  assign rd_idx  = INSTR[11:7];
  assign RS1_IDX = INSTR[19:15];
  assign RS2_IDX = INSTR[24:20];
  assign imm_i   = XLEN'($signed(INSTR[31:20]));
  assign imm_s   = XLEN'($signed({INSTR[31:25], INSTR[11:7]}));
  assign imm_u   = XLEN'($signed({INSTR[31:12], 12'b0}));

  logic [XLEN-1:0] a_d, b_d;
  logic [2:0]      ctl_d;
  logic            ill_d, store_d, rd_we_d;

  always_comb begin
    a_d     = RS1_DATA;
    b_d     = imm_i;
    ctl_d   = `ALU_ADD;
    ill_d   = 1'b0;
    store_d = 1'b0;
    case (opcode)
      7'b0110011: begin
        b_d = RS2_DATA;
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: ctl_d = `ALU_ADD;
          {7'b0100000, 3'b000}: ctl_d = `ALU_SUB;
          {7'b0000000, 3'b100}: ctl_d = `ALU_XOR;
          {7'b0000000, 3'b110}: ctl_d = `ALU_OR;
          {7'b0000000, 3'b111}: ctl_d = `ALU_AND;
          default:              ill_d = 1'b1;
        endcase
      end
      7'b0010011: begin
        case (funct3)
          3'b000:  ctl_d = `ALU_ADD;
          3'b100:  ctl_d = `ALU_XOR;
          3'b110:  ctl_d = `ALU_OR;
          3'b111:  ctl_d = `ALU_AND;
          default: ill_d = 1'b1;
        endcase
      end
      7'b0000011, 7'b1100111: ;
      7'b0100011: begin
        b_d     = imm_s;
        store_d = 1'b1;
      end
      7'b0110111: begin
        a_d = '0;
        b_d = imm_u;
      end
      7'b0010111: begin
        a_d = PC;
        b_d = imm_u;
      end
      default: ill_d = 1'b1;
    endcase
    // Illegal entries travel downstream as a zeroed ADD so the trap logic sees clean operands.
    if (ill_d) begin
      a_d   = '0;
      b_d   = '0;
      ctl_d = `ALU_ADD;
    end
    rd_we_d = !ill_d && !store_d && (rd_idx != 5'd0);
  end

  logic            valid_q, rd_we_q, ill_q;
  logic [XLEN-1:0] a_q, b_q, pc_q;
  logic [2:0]      ctl_q;
  logic [4:0]      rd_q;
  logic            capture;

  assign IN_READY = !valid_q || OUT_READY;
  assign capture  = IN_VALID && IN_READY && !FLUSH;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctl_q   <= `ALU_ADD;
      rd_q    <= '0;
      rd_we_q <= 1'b0;
      pc_q    <= '0;
      ill_q   <= 1'b0;
    end else if (FLUSH) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q <= 1'b1;
      a_q     <= a_d;
      b_q     <= b_d;
      ctl_q   <= ctl_d;
      rd_q    <= rd_idx;
      rd_we_q <= rd_we_d;
      pc_q    <= PC;
      ill_q   <= ill_d;
    end else if (OUT_READY) begin
      valid_q <= 1'b0;
    end
  end

  assign OUT_VALID   = valid_q;
  assign A           = a_q;
  assign B           = b_q;
  assign ALU_CONTROL = ctl_q;
  assign RD          = rd_q;
  assign RD_WE       = rd_we_q;
  assign PC_OUT      = pc_q;
  assign ILLEGAL     = ill_q;

endmodule
